// File: rtl/switch_pkg.sv
// rtl/switch_pkg.sv - shared types and constants for the switch egress path
package switch_pkg;

  localparam int NUM_PORTS = 4;

  localparam logic [3:0] PORT0_SOURCE = 4'b0001;
  localparam logic [3:0] PORT1_SOURCE = 4'b0010;
  localparam logic [3:0] PORT2_SOURCE = 4'b0100;
  localparam logic [3:0] PORT3_SOURCE = 4'b1000;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] tgt;
    logic [7:0] data;
  } pkt_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  // Saturating add used by the drop counter; several inputs may drop on one edge.
  function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] n);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {1'b0, n};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/switch_egress_port_if.sv
// rtl/switch_egress_port_if.sv - ingress monitor and egress handshake bundle
interface switch_egress_port_if #(
  parameter int NUM_PORTS = switch_pkg::NUM_PORTS
);
  logic [NUM_PORTS-1:0]      in_valid;
  logic [NUM_PORTS-1:0][3:0] in_source;
  logic [NUM_PORTS-1:0][3:0] in_target;
  logic [NUM_PORTS-1:0][7:0] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [3:0]                out_source;
  logic [3:0]                out_target;
  logic [7:0]                out_data;
  logic [7:0]                drop_count;

  modport master (
    output in_valid, in_source, in_target, in_data, out_ready,
    input  out_valid, out_source, out_target, out_data, drop_count
  );

  modport slave (
    input  in_valid, in_source, in_target, in_data, out_ready,
    output out_valid, out_source, out_target, out_data, drop_count
  );
endinterface

// File: rtl/switch_rr_arbiter.sv
// rtl/switch_rr_arbiter.sv - round-robin one-hot grant over the occupied holds
module switch_rr_arbiter #(
  parameter int NUM_PORTS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_en,
  output logic [NUM_PORTS-1:0] o_grant
);
  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_gidx;
  logic          w_found;

  // Search starts at the pointer so the input after the last winner goes first.
  always_comb begin
    o_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_idx = PW'((int'(r_ptr) + k) % NUM_PORTS);
      if (i_en && !w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_gidx         = w_idx;
        w_found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= (w_gidx == PW'(NUM_PORTS - 1)) ? '0 : w_gidx + PW'(1);
    end
  end
endmodule

// File: rtl/switch_egress_port.sv
// rtl/switch_egress_port.sv - egress collector: holds, RR arbiter, packet FIFO, output stage
// Optional drop counter enabled by SWITCH_EGRESS_DROP_CNT_EN.
module switch_egress_port
  import switch_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NUM_PORTS  = switch_pkg::NUM_PORTS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  switch_egress_port_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [NUM_PORTS-1:0] w_hit;
  logic [NUM_PORTS-1:0] w_grant;
  logic [NUM_PORTS-1:0] r_occ;
  pkt_t                 r_hold [NUM_PORTS];
  pkt_t                 w_grant_pkt;
  logic                 w_arb_en;

  pkt_t                 r_mem [FIFO_DEPTH];
  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_fifo_wr;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_load;
  pkt_t                 r_out;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_hit[i] = bus.in_valid[i] && bus.in_target[i][PORT_ID];
    end
  end

  always_comb begin
    w_grant_pkt = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_grant[i]) w_grant_pkt = w_grant_pkt | r_hold[i];
    end
  end

  // A hold granted this edge is free again, so a same-edge hit reloads it instead of dropping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ <= '0;
      for (int i = 0; i < NUM_PORTS; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_hit[i] && (!r_occ[i] || w_grant[i])) begin
          r_hold[i] <= {bus.in_source[i], bus.in_target[i], bus.in_data[i]};
          r_occ[i]  <= 1'b1;
        end else if (w_grant[i]) begin
          r_occ[i]  <= 1'b0;
        end
      end
    end
  end

  assign w_arb_en = !w_full;

  switch_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (r_occ),
    .i_en    (w_arb_en),
    .o_grant (w_grant)
  );

  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_wr = |w_grant;

  always_ff @(posedge clk) begin
    if (w_fifo_wr) r_mem[r_wr_ptr[AW-1:0]] <= w_grant_pkt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_load)    r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Reload on the handshake edge itself keeps the egress stream bubble-free.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (!w_empty) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.out_ready) begin
          if (!w_empty) w_load = 1'b1;
          else          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_out <= '0;
    else if (w_load) r_out <= r_mem[r_rd_ptr[AW-1:0]];
  end

  assign bus.out_valid  = (r_state == ST_SEND);
  assign bus.out_source = r_out.src;
  assign bus.out_target = r_out.tgt;
  assign bus.out_data   = r_out.data;

`ifdef SWITCH_EGRESS_DROP_CNT_EN
  logic [7:0] w_drop_n;
  logic [7:0] r_drop_cnt;

  always_comb begin
    w_drop_n = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_hit[i] && r_occ[i] && !w_grant[i]) w_drop_n = w_drop_n + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_drop_cnt <= '0;
    else        r_drop_cnt <= sat_inc(r_drop_cnt, w_drop_n);
  end

  assign bus.drop_count = r_drop_cnt;
`else
  assign bus.drop_count = '0;
`endif
endmodule

// File: tb/tb_switch_egress_port.sv
// tb/tb_switch_egress_port.sv - scoreboard bench for switch_egress_port (PORT_ID 2)
module tb_switch_egress_port;
  import switch_pkg::*;

  localparam int NP    = 4;
  localparam int PID   = 2;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switch_egress_port_if #(.NUM_PORTS(NP)) bus();

  switch_egress_port #(
    .PORT_ID    (PID),
    .NUM_PORTS  (NP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: hold occupancy, buffered-packet count and presented flag
  pkt_t exp_q[$];
  int   m_fcnt   = 0;
  bit   m_pres_v = 1'b0;
  bit   m_occ [NP];
  pkt_t m_hold [NP];
  int   m_ptr    = 0;
  int   m_drops  = 0;

  function automatic int exp_drop_count();
`ifdef SWITCH_EGRESS_DROP_CNT_EN
    return m_drops;
`else
    return 0;
`endif
  endfunction

  function automatic int occ_count();
    int n = 0;
    for (int i = 0; i < NP; i++) n += int'(m_occ[i]);
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_fcnt   = 0;
      m_pres_v = 1'b0;
      m_ptr    = 0;
      m_drops  = 0;
      for (int i = 0; i < NP; i++) m_occ[i] = 1'b0;
    end else begin
      bit hs, was_full, pop;
      int g, nd;
      hs       = m_pres_v && bus.out_ready;
      was_full = (m_fcnt == DEPTH);
      pop      = (!m_pres_v || hs) && (m_fcnt > 0);
      if (pop) m_pres_v = 1'b1;
      else if (hs) m_pres_v = 1'b0;
      g = -1;
      if (!was_full) begin
        for (int k = 0; k < NP; k++) begin
          if (g < 0 && m_occ[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
        end
      end
      if (g >= 0) begin
        exp_q.push_back(m_hold[g]);
        m_occ[g] = 1'b0;
        m_ptr    = (g + 1) % NP;
        m_fcnt++;
      end
      if (pop) m_fcnt--;
      nd = 0;
      for (int i = 0; i < NP; i++) begin
        if (bus.in_valid[i] && bus.in_target[i][PID]) begin
          if (m_occ[i]) nd++;
          else begin
            m_occ[i]  = 1'b1;
            m_hold[i] = {bus.in_source[i], bus.in_target[i], bus.in_data[i]};
          end
        end
      end
      m_drops = (m_drops + nd > 255) ? 255 : m_drops + nd;
    end
  end

  // Monitor: compares each cycle's outputs and pops the scoreboard on handshake
  logic prev_v   = 1'b0;
  logic prev_rdy = 1'b0;
  logic prev_rst = 1'b0;
  pkt_t prev_pkt = '0;
  pkt_t mon_got;
  pkt_t mon_exp;

  initial begin
    forever begin
      @(negedge clk);
      #1;
      mon_got = {bus.out_source, bus.out_target, bus.out_data};
      check("out_valid", bus.out_valid, m_pres_v);
      check("drop_count", bus.drop_count, exp_drop_count());
      if (rst_n && prev_rst && prev_v && !prev_rdy)
        check("stable_under_backpressure", mon_got, prev_pkt);
      if (rst_n && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("unexpected_packet", mon_got, 32'hDEAD);
        else begin
          mon_exp = exp_q.pop_front();
          check("egress_packet", mon_got, mon_exp);
        end
      end
      prev_v   = bus.out_valid;
      prev_rdy = bus.out_ready;
      prev_rst = rst_n;
      prev_pkt = mon_got;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = '0;
    end
  endtask

  task automatic set_in(input int i, input logic [3:0] s, input logic [3:0] t, input logic [7:0] d);
    bus.in_valid[i]  = 1'b1;
    bus.in_source[i] = s;
    bus.in_target[i] = t;
    bus.in_data[i]   = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n         = 1'b0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || occ_count() != 0) && n < budget) begin
      step(1);
      n++;
    end
    check("drain_complete", 32'(exp_q.size() + occ_count()), 0);
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_source = '0;
    bus.in_target = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_source", bus.out_source, 0);
    check("reset_out_target", bus.out_target, 0);
    check("reset_out_data", bus.out_data, 0);
    check("reset_drop_count", bus.drop_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single packet, two-cycle latency
    bus.out_ready = 1'b1;
    set_in(1, 4'b0010, 4'b0100, 8'hA5);
    step(3);
    #1;
    check("single_valid", bus.out_valid, 1);
    check("single_pkt", {bus.out_source, bus.out_target, bus.out_data}, {4'b0010, 4'b0100, 8'hA5});
    step(3);
    set_in(1, 4'b0010, 4'b0001, 8'hA5);
    step(6);

    // simultaneous arrivals, then a second burst with pointer at 1
    do_reset();
    bus.out_ready = 1'b1;
    for (int i = 0; i < NP; i++) set_in(i, 4'(1 << i), 4'b0100 | 4'(i), 8'(8'h10 + i));
    step(8);
    set_in(0, PORT0_SOURCE, 4'b0100, 8'h20);
    step(6);
    for (int i = 0; i < NP; i++) set_in(i, 4'(1 << i), 4'b1100, 8'(8'h30 + i));
    step(8);

    // backpressure: fill output, FIFO and hold, then collide on the hold
    do_reset();
    for (int p = 0; p < 6; p++) begin
      set_in(0, PORT0_SOURCE, 4'b0100, 8'(8'h40 + p));
      step(4);
    end
    set_in(0, PORT0_SOURCE, 4'b0100, 8'h4F);
    step(1);
    #1;
`ifdef SWITCH_EGRESS_DROP_CNT_EN
    check("backpressure_drop", bus.drop_count, 1);
`else
    check("backpressure_drop", bus.drop_count, 0);
`endif
    bus.out_ready = 1'b1;
    wait_drain(100);

    // back-to-back drain of a loaded FIFO
    bus.out_ready = 1'b0;
    for (int i = 0; i < NP; i++) set_in(i, 4'(1 << i), 4'b0100, 8'(8'h50 + i));
    step(8);
    bus.out_ready = 1'b1;
    wait_drain(50);

    // drop counter saturation
    do_reset();
    repeat (80) begin
      for (int i = 0; i < NP; i++) set_in(i, 4'(1 << i), 4'b1111, 8'($urandom));
      step(1);
    end
    #1;
`ifdef SWITCH_EGRESS_DROP_CNT_EN
    check("drop_saturated", bus.drop_count, 255);
`else
    check("drop_saturated", bus.drop_count, 0);
`endif

    // reset while presenting with packets buffered
    check("pre_reset_valid", bus.out_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", bus.out_valid, 0);
    check("midreset_pkt", {bus.out_source, bus.out_target, bus.out_data}, 0);
    check("midreset_drop", bus.drop_count, 0);
    step(2);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    step(12);

    // randomized traffic with random backpressure
    repeat (1500) begin
      @(negedge clk);
      for (int i = 0; i < NP; i++) begin
        bus.in_valid[i]  = ($urandom_range(0, 99) < 35);
        bus.in_source[i] = 4'(1 << $urandom_range(0, 3));
        bus.in_target[i] = 4'($urandom_range(0, 15));
        bus.in_data[i]   = 8'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 99) < 60);
    end
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    wait_drain(200);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/switch_egress_port.md
# switch_egress_port

Output-side collector for one port of the 4-port switch. Monitors the packet outputs of all `NUM_PORTS` per-port ingress FSMs. Accepts every packet whose one-hot target includes this port's bit, arbitrates round-robin among simultaneous arrivals and buffers accepted packets in a FIFO. Presents packets on a valid/ready egress interface, with drop accounting when buffering is exhausted.

## Interface
- `PORT_ID`, 0, index (0..NUM_PORTS-1) of this egress port; its one-hot bit is `1 << PORT_ID`
- `NUM_PORTS`, 4, number of ingress packet sources monitored
- `FIFO_DEPTH`, 4, packet FIFO entries; power of two, ≥2
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `in_valid` in [NUM_PORTS]: one-cycle packet pulse per ingress port
- `in_source` in [NUM_PORTS][4]: one-hot source per ingress port
- `in_target` in [NUM_PORTS][4]: one-hot/multi-hot target per ingress port
- `in_data` in [NUM_PORTS][8]: payload per ingress port
- `out_valid` out 1: egress packet present
- `out_ready` in 1: egress consumer accepts
- `out_source` out 4: source of presented packet
- `out_target` out 4: target of presented packet, unmodified
- `out_data` out 8: payload of presented packet
- `drop_count` out 8: saturating count of dropped packets

## Operation
- Match: input i hits when `in_valid[i] && in_target[i][PORT_ID]`. Multicast targets match on own bit only. Source is not filtered; loopback is accepted.
- Hold stage: one holding register plus an occupied flag per input. A hit with a free hold loads {src,tgt,data} and sets occupied.
- Collision: a hit on an occupied hold drops the NEW packet and keeps the held one. `drop_count` increments, saturating at 255.
- Arbiter: round-robin over occupied holds.
  - Pointer starts at input 0 after reset.
  - At most one grant per cycle, issued only when FIFO is not full.
  - The granted hold is written to the FIFO and cleared.
  - Pointer moves to granted+1 (mod NUM_PORTS).
  - A hold that is cleared by grant may be reloaded by a hit on the same edge.
- FIFO: `FIFO_DEPTH` entries, registered pointers with an extra wrap bit; full when pointers are equal and wrap bits differ.
  - Full blocks the write even if a read occurs the same cycle.
  - A write into an empty FIFO concurrent with a read is legal.
- Output FSM:
  - EMPTY: `out_valid`=0. Go to SEND and load the output register when the FIFO is non-empty.
  - SEND: `out_valid`=1; outputs stable until handshake (`out_valid && out_ready` at edge).
  - On handshake, if the FIFO is non-empty, reload and stay in SEND (back-to-back, no bubble); otherwise go to EMPTY.
- Reset values: `out_valid`=0, `out_source`=0, `out_target`=0, `out_data`=0, `drop_count`=0. All holds clear, FIFO empty, pointer 0.
- Reset mid-operation discards held, buffered and presented packets. No partial state survives.

## Timing
- Hit sampled at edge E0 → hold. E1 → FIFO write (if granted). E2 → output register, `out_valid`=1 after E2. Minimum latency is 2 cycles.
- Each extra pending hold or FIFO entry ahead adds ≥1 cycle.
- Sustained throughput is 1 packet/cycle with `out_ready`=1.
- `out_ready` may be held low indefinitely. Outputs must not change while `out_valid`=1 and no handshake has occurred.
- `drop_count` updates at the edge of the dropping hit. No wrap past 255.

## Configuration
- `SWITCH_EGRESS_DROP_CNT_EN` defined: the drop counter is implemented as above.
- Not defined: no counter logic; `drop_count` tied to 0. Drop behaviour itself is unchanged.

## Structure
- Shared package `switch_pkg`:
  - `NUM_PORTS` default
  - `PORT0_SOURCE`..`PORT3_SOURCE` one-hot constants
  - `pkt_t` packed struct {src[3:0], tgt[3:0], data[7:0]}
  - output FSM `state_t` enum
- One sub-module: `switch_rr_arbiter` (NUM_PORTS request vector, enable, grant one-hot, pointer update). FIFO and holds stay inline.

## Test plan
- Single packet: `in_valid[1]`, src 0010, tgt 0100, data A5 to `PORT_ID`=2 → `out_valid` 2 cycles later, src 0010/tgt 0100/data A5. Same packet to `PORT_ID`=0 → no output.
- Simultaneous hits: all 4 inputs pulse with data 10,11,12,13, targets incl. own bit → egress order 10,11,12,13. A second burst after pointer=1 starts at the input after the last grant.
- Backpressure: `out_ready`=0, 6 packets spaced 4 cycles, FIFO_DEPTH=4 → 4 FIFO + 1 output register + holds fill. A further hit on an occupied hold → `drop_count`=1 and the original held packet is preserved. Release `out_ready` → all retained packets emerge in order.
- Back-to-back drain: FIFO holding 3, `out_ready`=1 → `out_valid` continuous 3 cycles, data changes each cycle.
- Saturation (macro defined): force 300 collisions → `drop_count`=255. Macro undefined → stays 0.
- Reset mid-operation: assert `rst_n`=0 while `out_valid`=1 with 2 buffered → all outputs 0 immediately. After release, no stale packet appears.
